// File: rtl/crc_lfsr_gen.sv
// crc_lfsr_gen -- parametrised CRC generator built on a right-shift Galois LFSR.
//
// Absorbs DATA_W message bits per accepted beat (in_data[0] first). On the
// in_last beat the result is captured on crc_value, then shifted out serially,
// LSB first, under a valid/ready handshake. The block then returns to IDLE
// with the register reloaded to SEED.
//
// Optional feature (macro CRC_CHECK_EN): adds check_mode/crc_ok/chk_done.
// A frame whose in_last beat carries check_mode=1 skips the serial send.
// chk_done pulses the next cycle and crc_ok reports whether the residue was zero.
//
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   in_valid      input beat present
//   in_data       DATA_W message bits, bit 0 processed first
//   in_last       final beat of the message
//   in_ready      beat accepted when in_valid & in_ready (low while sending)
//   crc_out       serial CRC bit (registered)
//   crc_valid     crc_out valid (registered)
//   crc_ready     downstream accepts crc_out
//   crc_value     parallel CRC captured on the in_last beat
//   busy          frame in progress (CALC or SEND)
//   check_mode    [CRC_CHECK_EN] sampled with the in_last beat
//   crc_ok        [CRC_CHECK_EN] residue was zero, held until next chk_done
//   chk_done      [CRC_CHECK_EN] one-cycle pulse after a check frame
module crc_lfsr_gen #(
    parameter int                CRC_W    = 8,
    parameter logic [CRC_W-1:0]  TAP_MASK = 8'hC4,
    parameter logic [CRC_W-1:0]  SEED     = 8'hD8,
    parameter int                DATA_W   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              crc_out,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc_value,
`ifdef CRC_CHECK_EN
    input  logic              check_mode,
    output logic              crc_ok,
    output logic              chk_done,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] LAST_XFER = CNT_W'(CRC_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]       state;
    logic [CRC_W-1:0] lfsr;
    logic [CRC_W-1:0] nxt;
    logic [CNT_W-1:0] cnt;
    logic             fb;
    logic             accept;
    logic             chk_beat;

    assign in_ready = (state != SEND);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

`ifdef CRC_CHECK_EN
    assign chk_beat = check_mode;
`else
    assign chk_beat = 1'b0;
`endif

    // DATA_W single-bit Galois steps unrolled into one cycle.
    always_comb begin
        nxt = lfsr;
        fb  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb  = nxt[0] ^ in_data[i];
            nxt = (nxt >> 1) ^ (fb ? TAP_MASK : '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            lfsr      <= SEED;
            cnt       <= '0;
            crc_valid <= 1'b0;
            crc_out   <= 1'b0;
            crc_value <= '0;
        end else begin
            case (state)
                IDLE, CALC: begin
                    if (accept) begin
                        lfsr <= nxt;
                        if (in_last) begin
                            crc_value <= nxt;
                            if (chk_beat) begin
                                // check frames never send; go straight back idle
                                state <= IDLE;
                                lfsr  <= SEED;
                            end else begin
                                // first serial bit is presented on SEND entry
                                state     <= SEND;
                                crc_valid <= 1'b1;
                                crc_out   <= nxt[0];
                            end
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                SEND: begin
                    if (crc_ready) begin
                        if (cnt == LAST_XFER) begin
                            state     <= IDLE;
                            lfsr      <= SEED;
                            cnt       <= '0;
                            crc_valid <= 1'b0;
                            crc_out   <= 1'b0;
                        end else begin
                            lfsr    <= lfsr >> 1;
                            cnt     <= cnt + 1'b1;
                            // bit 1 becomes bit 0 after this shift
                            crc_out <= lfsr[1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            crc_ok   <= 1'b0;
            chk_done <= 1'b0;
        end else begin
            chk_done <= 1'b0;
            if (accept && in_last && check_mode) begin
                chk_done <= 1'b1;
                crc_ok   <= (nxt == '0);
            end
        end
    end
`endif

endmodule

// File: doc/crc_lfsr_gen.md
Name: crc_lfsr_gen

Overview:
- Parametrised serial/parallel-input CRC generator, successor to the fixed 8-bit serial CRC block.
- Absorbs DATA_W message bits per accepted beat into a CRC_W-bit Galois LFSR with a programmable tap mask and seed.
- On the last beat, streams the CRC out serially, LSB first, under a valid/ready handshake.
- Sits between the frame serializer and the line encoder.

Parameters:
- CRC_W, 8: CRC register width, 2..32.
- TAP_MASK, 8'hC4: right-shift Galois tap mask, CRC_W bits. Bit CRC_W-1 must be set. 8'hC4 reproduces the existing 8-bit polynomial.
- SEED, 8'hD8: LFSR load value, CRC_W bits.
- DATA_W, 1: message bits absorbed per accepted beat, 1..CRC_W.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat present.
- in_data  in  DATA_W  message bits; in_data[0] is processed first.
- in_last  in  1  marks the final beat of the message.
- in_ready  out  1  block accepts an input beat this cycle.
- crc_out  out  1  serial CRC bit.
- crc_valid  out  1  crc_out is valid.
- crc_ready  in  1  downstream accepts crc_out.
- crc_value  out  CRC_W  parallel CRC, captured at the in_last beat.
- busy  out  1  frame in progress (CALC or SEND state).

Behaviour:
- Reset (RST=1 at a rising CLK edge): state=IDLE, reg=SEED, bit counter=0, crc_valid=0, crc_out=0, crc_value=0, busy=0, in_ready=1. Reset takes priority over all other events, including mid-SEND; any partial frame is discarded.
- Single bit step: fb = reg[0] ^ d; reg' = (reg >> 1) ^ (fb ? TAP_MASK : 0).
- A beat applies the single bit step DATA_W times, in_data[0] first, combinationally within one cycle.
- A beat is accepted when in_valid & in_ready. in_ready = (state != SEND).
- States:
  - IDLE: reg=SEED. An accepted beat with in_last=0 updates reg and goes to CALC. An accepted beat with in_last=1 updates reg, captures crc_value=reg', and goes to SEND. A single-beat frame is legal.
  - CALC: an accepted beat updates reg. If in_last=1, capture crc_value=reg' and go to SEND. In the absence of a beat, hold reg.
  - SEND: crc_valid=1 and crc_out=reg[0] are registered outputs, valid the first cycle in SEND. On crc_valid & crc_ready: reg shifts right by 1 (zero fill) and the counter increments. After transfer number CRC_W: reload reg=SEED, clear the counter, go to IDLE, and drop crc_valid the next cycle. If crc_ready=0: hold crc_out, crc_valid, reg and the counter. in_valid is ignored (in_ready=0).
- Latency: the first CRC bit is valid in the cycle after the in_last beat is accepted. With crc_ready held high, exactly CRC_W consecutive crc_valid cycles follow.
- Back-to-back frames: in_ready rises the cycle after the final CRC transfer. That cycle, the block is in IDLE with reg=SEED.
- crc_value holds its captured value until the next in_last capture or reset.
- The counter is ceil(log2(CRC_W+1)) bits wide and does not wrap within a frame.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined: adds input check_mode (1 bit, sampled with the in_last beat) and outputs crc_ok (1) and chk_done (1), both reset to 0.
  - With check_mode=1 on the in_last beat, the block skips SEND and returns directly to IDLE with reg=SEED.
  - In the next cycle, chk_done pulses for exactly 1 cycle and crc_ok = (reg'==0). crc_ok holds until the next chk_done.
  - Check mode requires the message to be followed by its CRC, fed LSB first.
- Undefined: no check_mode, crc_ok or chk_done ports; every frame ends in SEND.

Test Plan:
- Reset and idle: hold RST high for 2 cycles, then release -> in_ready=1, crc_valid=0, busy=0, crc_value=0.
- Default parameters, single beat in_data=0 with in_last=1, crc_ready=1 -> crc_value=8'h6C; crc_out sequence 0,0,1,1,0,1,1,0 over 8 consecutive crc_valid cycles; in_ready returns high on the following cycle.
- Single beat in_data=1 with in_last=1 -> crc_value=8'hA8; serial sequence 0,0,0,1,0,1,0,1.
- Backpressure: repeat the 8'h6C case with crc_ready low for 3 cycles after bit 2 -> crc_out holds 1 and crc_valid stays high for those 3 cycles; the sequence completes unchanged; in_valid asserted in SEND is not accepted.
- Reset mid-frame: assert RST during the 4th crc_valid cycle -> next cycle crc_valid=0, state IDLE. A new frame with bit 0 yields 8'h6C again.
- CRC_CHECK_EN, check_mode=1: feed bit 0, then 0,0,1,1,0,1,1,0 with in_last on the final bit -> chk_done pulses once with crc_ok=1 and no crc_valid. Flip any one bit -> crc_ok=0.
